// File: rtl/retime_pkg.sv
// Shared definitions for the reference retiming controller: FSM states and
// default window/threshold/blanking constants.
package retime_pkg;

    localparam int WIN_DEF   = 16;
    localparam int THR_DEF   = 4;
    localparam int BLANK_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_TRACK,
        ST_BLANK
    } state_t;

endpackage

// File: rtl/retime_mis_det.sv
// Rise detection on both retimed references and classification of each
// selected rise as a match or mismatch against the other retiming edge.
module retime_mis_det (
    input  logic clk,
    input  logic rst,
    input  logic sel_neg,
    input  logic track,
    input  logic fref_p,
    input  logic fref_n,
    output logic rs,
    output logic mis
);

    logic p_q;
    logic n_q;
    logic rp;
    logic rn;
    logic rp_d;
    logic rn_d;
    logic ro;
    logic ro_d;
    logic hit_q;
    logic pending;

    assign rp   = fref_p & ~p_q;
    assign rn   = fref_n & ~n_q;
    assign rs   = sel_neg ? rn : rp;
    assign ro   = sel_neg ? rp : rn;
    assign ro_d = sel_neg ? rp_d : rn_d;

    // hit_q remembers whether the other edge was seen in the rise cycle or
    // the one before; the cycle after only needs to check ro itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= 1'b0;
            n_q     <= 1'b0;
            rp_d    <= 1'b0;
            rn_d    <= 1'b0;
            hit_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            p_q   <= fref_p;
            n_q   <= fref_n;
            rp_d  <= rp;
            rn_d  <= rn;
            hit_q <= ro | ro_d;
            if (!track || pending)
                pending <= 1'b0;
            else
                pending <= rs;
        end
    end

    assign mis = track & pending & ~(hit_q | ro);

endmodule

// File: rtl/retime_ctrl.sv
// Retiming edge controller: tracks reference edges per window, switches the
// retiming edge on excessive mismatches and reports lock and statistics.
module retime_ctrl
    import retime_pkg::*;
#(
    parameter int WIN   = WIN_DEF,
    parameter int THR   = THR_DEF,
    parameter int BLANK = BLANK_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fref_p,
    input  logic             fref_n,
    output logic             ckr_en,
    output logic             sel_neg,
    output logic             locked,
    output logic [CNT_W-1:0] mism_cnt
);

    localparam int EW = $clog2(WIN + 1);
    localparam int MW = $clog2(THR + 1);
    localparam int BW = $clog2(BLANK + 1);

    localparam logic [EW-1:0] WIN_C      = EW'(WIN);
    localparam logic [MW-1:0] THR_C      = MW'(THR);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);

    state_t state;
    state_t state_n;

    logic [EW-1:0]    edge_cnt;
    logic [EW-1:0]    edge_n;
    logic [EW-1:0]    edge_inc;
    logic [MW-1:0]    win_mis;
    logic [MW-1:0]    wmis_n;
    logic [MW-1:0]    wmis_inc;
    logic [BW-1:0]    blank_cnt;
    logic [BW-1:0]    blank_n;
    logic             acq_cnt;
    logic             acq_n;
    logic             sel_n;
    logic             locked_n;
    logic             ckr_n;
    logic [CNT_W-1:0] mism_n;
    logic             track;
    logic             rs;
    logic             mis;

    assign track = (state == ST_TRACK) & en;

    retime_mis_det u_mis_det (
        .clk     (clk),
        .rst     (rst),
        .sel_neg (sel_neg),
        .track   (track),
        .fref_p  (fref_p),
        .fref_n  (fref_n),
        .rs      (rs),
        .mis     (mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            edge_cnt  <= '0;
            win_mis   <= '0;
            blank_cnt <= '0;
            acq_cnt   <= 1'b0;
            sel_neg   <= 1'b0;
            locked    <= 1'b0;
            ckr_en    <= 1'b0;
            mism_cnt  <= '0;
        end else begin
            state     <= state_n;
            edge_cnt  <= edge_n;
            win_mis   <= wmis_n;
            blank_cnt <= blank_n;
            acq_cnt   <= acq_n;
            sel_neg   <= sel_n;
            locked    <= locked_n;
            ckr_en    <= ckr_n;
            mism_cnt  <= mism_n;
        end
    end

    // A mismatch landing in the same cycle as a window end is folded into
    // wmis_inc first, so the switch decision always sees it.
    always_comb begin
        state_n  = state;
        edge_n   = edge_cnt;
        wmis_n   = win_mis;
        blank_n  = blank_cnt;
        acq_n    = acq_cnt;
        sel_n    = sel_neg;
        locked_n = locked;
        ckr_n    = 1'b0;
        mism_n   = mism_cnt;
        edge_inc = edge_cnt + EW'(rs);
        wmis_inc = win_mis + MW'(mis);

        if (mis && !(&mism_cnt))
            mism_n = mism_cnt + CNT_W'(1);

        if (!en) begin
            state_n = ST_IDLE;
            edge_n  = '0;
            wmis_n  = '0;
            blank_n = '0;
            acq_n   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_ACQ;
                    acq_n   = 1'b0;
                end
                ST_ACQ: begin
                    if (rs) begin
                        if (acq_cnt) begin
                            state_n = ST_TRACK;
                            acq_n   = 1'b0;
                        end else begin
                            acq_n = 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    ckr_n  = rs;
                    edge_n = edge_inc;
                    wmis_n = wmis_inc;
                    if (wmis_inc >= THR_C) begin
                        sel_n    = ~sel_neg;
                        locked_n = 1'b0;
                        edge_n   = '0;
                        wmis_n   = '0;
                        blank_n  = '0;
                        ckr_n    = 1'b0;
                        state_n  = ST_BLANK;
                    end else if (edge_inc == WIN_C) begin
                        locked_n = (wmis_inc == '0);
                        edge_n   = '0;
                        wmis_n   = '0;
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        blank_n = '0;
                        acq_n   = 1'b0;
                        state_n = ST_ACQ;
                    end else begin
                        blank_n = blank_cnt + BW'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_retime_ctrl.sv
// Self-checking bench for retime_ctrl: fixed vectors, directed corner
// sequences and randomized references against an edge-level reference model.
module tb_retime_ctrl;

    localparam int WIN   = 16;
    localparam int THR   = 4;
    localparam int BLANK = 8;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_TRACK = 2;
    localparam int M_BLANK = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic             fref_p;
    logic             fref_n;
    logic             ckr_en;
    logic             sel_neg;
    logic             locked;
    logic [CNT_W-1:0] mism_cnt;

    int n_cmp;
    int n_fail;
    int ph;
    int ckr_seen;

    // reference model state
    int m_mode;
    bit m_fp_prev;
    bit m_fn_prev;
    bit m_rp_h[3];
    bit m_rn_h[3];
    bit m_pend;
    bit m_pend_sel;
    int m_acq;
    int m_edges;
    int m_wmis;
    int m_blank;
    bit m_ckr;
    bit m_sel;
    bit m_locked;
    int m_mism;

    typedef struct {
        bit rst;
        bit en;
        bit fp;
        bit fn;
        bit ckr;
        bit sel;
        bit lck;
        int mism;
    } vec_t;

    vec_t tbl[10];

    retime_ctrl #(
        .WIN   (WIN),
        .THR   (THR),
        .BLANK (BLANK),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .fref_p   (fref_p),
        .fref_n   (fref_n),
        .ckr_en   (ckr_en),
        .sel_neg  (sel_neg),
        .locked   (locked),
        .mism_cnt (mism_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model works per reference edge: a selected rise is judged once the
    // following cycle is known, by looking back over a three-cycle window.
    task automatic model_step(input bit r, input bit e, input bit fp, input bit fn);
        bit rp, rn, rs, mis, had_pend, active, other_seen;
        if (r) begin
            m_mode = M_IDLE; m_fp_prev = 0; m_fn_prev = 0;
            m_rp_h = '{0, 0, 0}; m_rn_h = '{0, 0, 0};
            m_pend = 0; m_pend_sel = 0;
            m_acq = 0; m_edges = 0; m_wmis = 0; m_blank = 0;
            m_ckr = 0; m_sel = 0; m_locked = 0; m_mism = 0;
            return;
        end
        rp = fp && !m_fp_prev;
        rn = fn && !m_fn_prev;
        m_fp_prev = fp;
        m_fn_prev = fn;
        m_rp_h[2] = m_rp_h[1]; m_rp_h[1] = m_rp_h[0]; m_rp_h[0] = rp;
        m_rn_h[2] = m_rn_h[1]; m_rn_h[1] = m_rn_h[0]; m_rn_h[0] = rn;

        active   = e && (m_mode == M_TRACK);
        mis      = 0;
        had_pend = m_pend;
        if (m_pend) begin
            if (active) begin
                other_seen = m_pend_sel ? (m_rp_h[0] || m_rp_h[1] || m_rp_h[2])
                                        : (m_rn_h[0] || m_rn_h[1] || m_rn_h[2]);
                mis = !other_seen;
            end
            m_pend = 0;
        end
        rs = m_sel ? rn : rp;
        if (active && rs && !had_pend) begin
            m_pend     = 1;
            m_pend_sel = m_sel;
        end

        m_ckr = 0;
        if (mis && m_mism < MAXC) m_mism++;
        if (!e) begin
            m_mode = M_IDLE; m_acq = 0; m_edges = 0; m_wmis = 0; m_blank = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode = M_ACQ;
                    m_acq  = 0;
                end
                M_ACQ: begin
                    if (rs) begin
                        m_acq++;
                        if (m_acq == 2) begin
                            m_mode = M_TRACK;
                            m_acq  = 0;
                        end
                    end
                end
                M_TRACK: begin
                    m_ckr = rs;
                    if (mis) m_wmis++;
                    if (rs) m_edges++;
                    if (m_wmis >= THR) begin
                        m_sel = !m_sel; m_locked = 0;
                        m_edges = 0; m_wmis = 0; m_blank = 0;
                        m_mode = M_BLANK; m_ckr = 0;
                    end else if (m_edges == WIN) begin
                        m_locked = (m_wmis == 0);
                        m_edges = 0; m_wmis = 0;
                    end
                end
                default: begin
                    m_blank++;
                    if (m_blank == BLANK) begin
                        m_mode = M_ACQ; m_blank = 0; m_acq = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit p, input bit n);
        @(negedge clk);
        rst    = r;
        en     = e;
        fref_p = p;
        fref_n = n;
        model_step(r, e, p, n);
        @(posedge clk);
        #1;
        if (ckr_en === 1'b1) ckr_seen++;
    endtask

    task automatic checkOutput(input string tag);
        check_val({tag, ".ckr_en"},   int'(ckr_en),   int'(m_ckr));
        check_val({tag, ".sel_neg"},  int'(sel_neg),  int'(m_sel));
        check_val({tag, ".locked"},   int'(locked),   int'(m_locked));
        check_val({tag, ".mism_cnt"}, int'(mism_cnt), m_mism);
    endtask

    // fref_p rises at phase 0 of each period, fref_n rises lag cycles later
    task automatic pattern_cycle(input int period, input int lag, input bit e, input string tag);
        bit p, n;
        p = (ph % period) < (period / 2);
        n = (((ph - lag) % period + period) % period) < (period / 2);
        ph++;
        applyStimulus(1'b0, e, p, n);
        checkOutput(tag);
    endtask

    task automatic start_scenario(input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput(tag);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput(tag);
        ph       = 0;
        ckr_seen = 0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; ph = 0; ckr_seen = 0;
        rst = 1'b1; en = 1'b0; fref_p = 1'b0; fref_n = 1'b0;

        // reset, acquisition of two edges, first tracked edge, enable drop
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 1, 1, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 1, 1, 1, 0, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{0, 1, 1, 1, 1, 0, 0, 0};
        tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        tbl[9] = '{1, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].fp, tbl[i].fn);
            check_val($sformatf("vec%0d.ckr_en", i),   int'(ckr_en),   int'(tbl[i].ckr));
            check_val($sformatf("vec%0d.sel_neg", i),  int'(sel_neg),  int'(tbl[i].sel));
            check_val($sformatf("vec%0d.locked", i),   int'(locked),   int'(tbl[i].lck));
            check_val($sformatf("vec%0d.mism_cnt", i), int'(mism_cnt), tbl[i].mism);
            checkOutput($sformatf("vec%0d_model", i));
        end

        // aligned references: two discarded edges, lock after a clean window
        start_scenario("aligned");
        for (int i = 0; i < 17 * 20; i++) pattern_cycle(20, 0, 1'b1, "aligned");
        check_val("aligned.locked_before_window", int'(locked), 0);
        for (int i = 0; i < 3 * 20; i++) pattern_cycle(20, 0, 1'b1, "aligned");
        check_val("aligned.locked", int'(locked), 1);
        check_val("aligned.ckr_pulses", ckr_seen, 18);
        check_val("aligned.mism_cnt", int'(mism_cnt), 0);

        // one-cycle lag on alternate edges stays inside the tolerance
        start_scenario("altlag");
        for (int i = 0; i < 20 * 20; i++) pattern_cycle(20, (ph / 20) % 2, 1'b1, "altlag");
        check_val("altlag.locked", int'(locked), 1);
        check_val("altlag.mism_cnt", int'(mism_cnt), 0);
        check_val("altlag.sel_neg", int'(sel_neg), 0);

        // three-cycle lag: switch after the fourth mismatch, then blanking
        start_scenario("lag3");
        for (int i = 0; i < 400 && sel_neg !== 1'b1; i++) pattern_cycle(20, 3, 1'b1, "lag3");
        check_val("lag3.switched", int'(sel_neg), 1);
        check_val("lag3.mism_cnt", int'(mism_cnt), 4);
        check_val("lag3.locked", int'(locked), 0);
        for (int i = 0; i < BLANK; i++) begin
            pattern_cycle(20, 3, 1'b1, "lag3_blank");
            check_val("lag3.blank_ckr", int'(ckr_en), 0);
        end

        // reset in the middle of blanking
        start_scenario("rstblank");
        for (int i = 0; i < 400 && sel_neg !== 1'b1; i++) pattern_cycle(20, 3, 1'b1, "rstblank");
        check_val("rstblank.switched", int'(sel_neg), 1);
        for (int i = 0; i < 3; i++) pattern_cycle(20, 3, 1'b1, "rstblank");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        check_val("rstblank.ckr_en", int'(ckr_en), 0);
        check_val("rstblank.sel_neg", int'(sel_neg), 0);
        check_val("rstblank.locked", int'(locked), 0);
        check_val("rstblank.mism_cnt", int'(mism_cnt), 0);
        checkOutput("rstblank");

        // complementary references: every edge mismatches until saturation
        start_scenario("sat");
        for (int i = 0; i < 6000 && mism_cnt !== CNT_W'(MAXC); i++) pattern_cycle(6, 3, 1'b1, "sat");
        check_val("sat.reached", int'(mism_cnt), MAXC);
        for (int i = 0; i < 120; i++) pattern_cycle(6, 3, 1'b1, "sat_hold");
        check_val("sat.hold", int'(mism_cnt), MAXC);

        // enable dropped mid-window after lock
        start_scenario("endrop");
        for (int i = 0; i < 20 * 20 + 5; i++) pattern_cycle(20, 0, 1'b1, "endrop");
        check_val("endrop.locked_before", int'(locked), 1);
        for (int i = 0; i < 40; i++) begin
            pattern_cycle(20, 0, 1'b0, "endrop_off");
            check_val("endrop.ckr_en", int'(ckr_en), 0);
            check_val("endrop.locked", int'(locked), 1);
        end

        // randomized references, enable and rare resets against the model
        start_scenario("rand");
        begin
            bit p, n, e;
            p = 0; n = 0; e = 1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 2) == 0) p = !p;
                if ($urandom_range(0, 2) == 0) n = !n;
                if ($urandom_range(0, 149) == 0) e = !e;
                if (!e && $urandom_range(0, 9) == 0) e = 1;
                applyStimulus($urandom_range(0, 699) == 0, e, p, n);
                checkOutput("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/retime_ctrl.md
RETIME_CTRL -- requirements
Module: retime_ctrl

Interface
REQ-001 SHALL have parameter WIN, default 16, meaning the number of reference edges per evaluation window.
REQ-002 SHALL have parameter THR, default 4, meaning the mismatch count per window that triggers an edge switch.
REQ-003 SHALL have parameter BLANK, default 8, meaning the clk cycles of suppressed output after a switch.
REQ-004 SHALL have parameter CNT_W, default 8, meaning the width of the mismatch statistics counter.
REQ-005 SHALL have port clk, input, 1 bit, meaning the DCO clock; it is the only clock.
REQ-006 SHALL have port rst, input, 1 bit, meaning a synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit, meaning controller enable.
REQ-008 SHALL have port fref_p, input, 1 bit, meaning the reference retimed on clk posedge and already synchronized to clk posedge.
REQ-009 SHALL have port fref_n, input, 1 bit, meaning the reference retimed on clk negedge and re-registered on clk posedge.
REQ-010 SHALL have port ckr_en, output, 1 bit, meaning a one-cycle pulse per accepted reference edge.
REQ-011 SHALL have port sel_neg, output, 1 bit, meaning the retiming edge in use: 0 is posedge, 1 is negedge.
REQ-012 SHALL have port locked, output, 1 bit, meaning a clean window was completed with no switch.
REQ-013 SHALL have port mism_cnt, output, CNT_W bits, meaning the total mismatches, saturating.

Function
REQ-014 SHALL register fref_p and fref_n once internally and SHALL form the rise pulses rp and rn as current AND NOT previous value.
REQ-015 SHALL define the selected rise rs as rn when sel_neg=1, otherwise rp, and the other rise ro as the complement choice.
REQ-016 SHALL classify each rs at cycle k as a mismatch unless ro occurred in cycle k-1, k or k+1; classification SHALL complete at cycle k+1.
REQ-017 SHALL implement the FSM states IDLE, ACQ, TRACK and BLANK.
REQ-018 SHALL transition IDLE->ACQ on en=1, and from any state SHALL return to IDLE within 1 cycle on en=0 while clearing the window counters.
REQ-019 SHALL, in ACQ, discard the first 2 rs events (pipeline fill) with no ckr_en, then enter TRACK.
REQ-020 SHALL, in TRACK, assert ckr_en in the cycle after each rs (latency 1 from rs), so ckr_en is never 2 consecutive cycles.
REQ-021 SHALL, in TRACK, count rs events (edge_cnt) and mismatches (win_mis) per window of WIN edges.
REQ-022 SHALL, when win_mis reaches THR, toggle sel_neg on the next cycle, clear locked, clear the window counters and enter BLANK, even mid-window.
REQ-023 SHALL, when edge_cnt reaches WIN with win_mis<THR, restart the window and set locked=1 only if win_mis==0.
REQ-024 SHALL keep locked cleared on any nonzero-mismatch window.
REQ-025 SHALL, in BLANK, hold ckr_en=0 for exactly BLANK cycles, ignore rise pulses, then enter ACQ.
REQ-026 SHALL increment mism_cnt on each classified mismatch and saturate it at all-ones with no wrap.
REQ-027 SHALL treat a mismatch and a window end in the same cycle with the mismatch counted first, then apply REQ-022 or REQ-023.
REQ-028 SHALL drop an rs arriving while the previous rs is still being classified from classification, while still emitting ckr_en for it.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, set the state to IDLE, ckr_en=0, sel_neg=0, locked=0 and mism_cnt=0, and clear all pipeline and counter registers.
REQ-030 SHALL give rst priority over en and over all FSM transitions, including mid-BLANK and mid-window.

Structure
REQ-031 SHALL place the FSM state enum and the default constants for WIN, THR and BLANK in shared package retime_pkg.
REQ-032 SHALL implement the edge detector plus mismatch classifier as one sub-module, retime_mis_det, instantiated once.
REQ-033 SHALL be synthesizable with no delays and no $time usage.

Verification
REQ-034 SHALL cover: rst then en=1, fref_p and fref_n rising in the same cycle every 20 cycles -> 2 edges without ckr_en, then ckr_en every 20 cycles, locked=1 after 16 edges.
REQ-035 SHALL cover: fref_n lagging fref_p by 3 cycles on every edge, sel_neg=0 -> sel_neg=1 one cycle after the 4th mismatch, ckr_en=0 for 8 cycles, mism_cnt=4.
REQ-036 SHALL cover: lag of 1 cycle on alternate edges -> zero mismatches, no switch, locked=1.
REQ-037 SHALL cover: forced mismatches past 255 with CNT_W=8 -> mism_cnt holds 255.
REQ-038 SHALL cover: rst pulsed mid-BLANK -> all outputs at reset values the next cycle, and sel_neg=0.
REQ-039 SHALL cover: en deasserted mid-window -> IDLE next cycle, ckr_en=0, locked unchanged until reset.
